// File: rtl/wheel_speed_mc.sv
// Multi-channel wheel-speed counter: per-channel synchronised edge counting over a
// fixed enabled-clock window, with saturation/overflow flags and a one-cycle valid strobe.
module wheel_speed_mc #(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 8,
  parameter int WINDOW_CYCLES = 50000,
  parameter int EDGE_MODE     = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    en,
  input  logic [N_CH-1:0]         pulse_in,
  output logic [N_CH*CNT_W-1:0]   count_out,
  output logic [N_CH-1:0]         ovf_out,
  output logic                    valid
);

  localparam int TW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(WINDOW_CYCLES - 1);

  logic [N_CH-1:0]            sync1;
  logic [N_CH-1:0]            sync2;
  logic [N_CH-1:0]            prev;
  logic [N_CH-1:0]            hit;
  logic [N_CH-1:0]            ovf;
  logic [N_CH-1:0]            ovf_nxt;
  logic [N_CH-1:0][CNT_W-1:0] cnt;
  logic [N_CH-1:0][CNT_W-1:0] cnt_nxt;
  logic [1:0]                 arm;
  logic                       armed;
  logic                       terminal;
  logic [TW-1:0]              timer;

  assign armed    = (arm == 2'd3);
  assign terminal = en && (timer == T_LAST);

  // Next counter values include an edge seen in the terminal cycle, so the
  // latched result and the running counters share one computation.
  always_comb begin
    if (EDGE_MODE != 0) hit = sync2 ^ prev;
    else                hit = sync2 & ~prev;
    if (!(armed && en)) hit = '0;
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      if (hit[ch]) begin
        if (cnt[ch] == '1) ovf_nxt[ch] = 1'b1;
        else               cnt_nxt[ch] = cnt[ch] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1     <= '0;
      sync2     <= '0;
      prev      <= '0;
      arm       <= '0;
      timer     <= '0;
      cnt       <= '0;
      ovf       <= '0;
      count_out <= '0;
      ovf_out   <= '0;
      valid     <= 1'b0;
    end else begin
      sync1 <= pulse_in;
      sync2 <= sync1;
      prev  <= sync2;
      if (!armed) arm <= arm + 2'd1;
      valid <= terminal;
      if (terminal) begin
        count_out <= cnt_nxt;
        ovf_out   <= ovf_nxt;
        cnt       <= '0;
        ovf       <= '0;
        timer     <= '0;
      end else if (en) begin
        cnt   <= cnt_nxt;
        ovf   <= ovf_nxt;
        timer <= timer + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wheel_speed_mc.sv
// Directed bench for wheel_speed_mc: rising/both-edge counting, saturation,
// terminal-cycle edge, mid-window reset with arming, and enable hold.
module tb_wheel_speed_mc;

  localparam int R = 563;  // first cycle of the epoch after the mid-window reset

  logic        CLK = 1'b0;
  logic        RST;
  logic        en;
  logic [1:0]  pa;
  logic [1:0]  ps;
  logic [15:0] cnt_r, cnt_b;
  logic [7:0]  cnt_s;
  logic [1:0]  ovf_r, ovf_b, ovf_s;
  logic        val_r, val_b, val_s;
  int          cyc;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 CLK = ~CLK;

  wheel_speed_mc #(.N_CH(2), .CNT_W(8), .WINDOW_CYCLES(100), .EDGE_MODE(0)) u_rise (
    .CLK(CLK), .RST(RST), .en(en), .pulse_in(pa),
    .count_out(cnt_r), .ovf_out(ovf_r), .valid(val_r));

  wheel_speed_mc #(.N_CH(2), .CNT_W(8), .WINDOW_CYCLES(100), .EDGE_MODE(1)) u_both (
    .CLK(CLK), .RST(RST), .en(en), .pulse_in(pa),
    .count_out(cnt_b), .ovf_out(ovf_b), .valid(val_b));

  wheel_speed_mc #(.N_CH(2), .CNT_W(4), .WINDOW_CYCLES(100), .EDGE_MODE(0)) u_sat (
    .CLK(CLK), .RST(RST), .en(en), .pulse_in(ps),
    .count_out(cnt_s), .ovf_out(ovf_s), .valid(val_s));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  function automatic logic exp_valid(input int c);
    return (c inside {100, 200, 300, 400, 500, R + 100, R + 230, R + 330});
  endfunction

  task automatic drive();
    RST = (cyc >= 560 && cyc <= 562);
    en  = !(cyc >= R + 140 && cyc <= R + 169);
    if      (cyc < 298)     pa[0] = 1'((cyc / 5) % 2);
    else if (cyc < 397)     pa[0] = 1'b0;
    else if (cyc < 500)     pa[0] = 1'b1;
    else if (cyc < 560)     pa[0] = 1'(((cyc - 500) / 5) % 2);
    else if (cyc < R + 100) pa[0] = 1'b1;
    else                    pa[0] = 1'(((cyc - R - 100) / 5) % 2);
    pa[1] = 1'b0;
    ps[0] = (cyc < 198) ? 1'(cyc % 2) : 1'b0;
    ps[1] = (cyc >= 398 && cyc <= 497) ? 1'(cyc % 2) : 1'b0;
  endtask

  task automatic check_cycle();
    check("valid_rise", 32'(val_r), 32'(exp_valid(cyc)));
    check("valid_both", 32'(val_b), 32'(exp_valid(cyc)));
    check("valid_sat",  32'(val_s), 32'(exp_valid(cyc)));
    if (cyc == 200 || cyc == 300) begin
      check("rise_count", 32'(cnt_r), 32'h000A);
      check("rise_ovf",   32'(ovf_r), 32'h0);
      check("both_count", 32'(cnt_b), 32'h0014);
      check("both_ovf",   32'(ovf_b), 32'h0);
    end
    if (cyc == 200) begin
      check("sat_count", 32'(cnt_s), 32'h0F);
      check("sat_ovf",   32'(ovf_s), 32'h1);
    end
    if (cyc == 300) begin
      check("sat_idle_count", 32'(cnt_s), 32'h00);
      check("sat_idle_ovf",   32'(ovf_s), 32'h0);
    end
    if (cyc == 400) check("term_edge_count", 32'(cnt_r), 32'h0001);
    if (cyc == 500) begin
      check("after_term_count", 32'(cnt_r), 32'h0000);
      check("sat_ch1_count",    32'(cnt_s), 32'hF0);
      check("sat_ch1_ovf",      32'(ovf_s), 32'h2);
    end
    if (cyc == 561) begin
      check("rst_sat_count", 32'(cnt_s), 32'h00);
      check("rst_sat_ovf",   32'(ovf_s), 32'h0);
      check("rst_rise_count", 32'(cnt_r), 32'h0000);
    end
    if (cyc == R + 100) begin
      check("armed_count", 32'(cnt_r), 32'h0000);
      check("armed_ovf",   32'(ovf_r), 32'h0);
    end
    if (cyc == R + 230) check("en_hold_count", 32'(cnt_r), 32'h000A);
    if (cyc == R + 330) check("after_hold_count", 32'(cnt_r), 32'h000A);
  endtask

  initial begin
    RST = 1'b1;
    en  = 1'b1;
    pa  = '0;
    ps  = '0;
    cyc = -1;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_cnt_rise", 32'(cnt_r), 32'h0);
    check("reset_cnt_both", 32'(cnt_b), 32'h0);
    check("reset_cnt_sat",  32'(cnt_s), 32'h0);
    check("reset_ovf_rise", 32'(ovf_r), 32'h0);
    check("reset_ovf_sat",  32'(ovf_s), 32'h0);
    check("reset_valid",    32'(val_r), 32'h0);
    cyc = 0;
    while (cyc <= R + 335) begin
      drive();
      check_cycle();
      @(posedge CLK);
      #1;
      cyc++;
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
